// File: rtl/idt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : idt_pkg
// Description : Shared state encoding, default widths and MISR fold helper
//               for the identity vector player.
// Revision    : 1.0
// ============================================================================
package idt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } idt_state_e;

    localparam int          IDT_IN_W     = 54;
    localparam int          IDT_OUT_W    = 376;
    localparam int          IDT_DEPTH    = 32;
    localparam int          IDT_LAT      = 0;
    localparam int          IDT_SIG_W    = 32;
    localparam logic [31:0] IDT_SIG_POLY = 32'h04C11DB7;

    // Upper bounds of the generic fold; callers zero-extend y and truncate the result.
    localparam int FOLD_MAX_OUT_W = 1024;
    localparam int FOLD_MAX_SIG_W = 64;

    // Bit i of y lands on bit (i mod sig_w): XOR of sig_w-wide slices, top slice zero-padded.
    function automatic logic [FOLD_MAX_SIG_W-1:0] idt_fold(
        input logic [FOLD_MAX_OUT_W-1:0] y,
        input int                        sig_w
    );
        logic [FOLD_MAX_SIG_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < FOLD_MAX_OUT_W; i++) begin
            acc = acc ^ (FOLD_MAX_SIG_W'(y[i]) << (i % sig_w));
        end
        return acc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/idt_misr.sv
`default_nettype none
// ============================================================================
// Module      : idt_misr
// Description : Multiple-input signature register compacting one DUT output
//               stream; seeded all-ones, advanced once per enabled sample.
// Revision    : 1.0
// ============================================================================
module idt_misr
    import idt_pkg::*;
#(
    parameter int               SIG_W    = IDT_SIG_W,
    parameter int               OUT_W    = IDT_OUT_W,
    parameter logic [SIG_W-1:0] SIG_POLY = SIG_W'(IDT_SIG_POLY)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             seed,
    input  logic             en,
    input  logic [OUT_W-1:0] y,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (seed) begin
            sig_d = '1;
        end else if (en) begin
            sig_d = {sig_q[SIG_W-2:0], 1'b0}
                  ^ (sig_q[SIG_W-1] ? SIG_POLY : '0)
                  ^ SIG_W'(idt_fold(FOLD_MAX_OUT_W'(y), SIG_W));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule
`default_nettype wire

// File: rtl/idt_vector_player.sv
`default_nettype none
// ============================================================================
// Module      : idt_vector_player
// Description : Replays stored stimulus into reference and synthesised DUT
//               copies, compares outputs bit-exactly and reports the result.
//               Optional MISR signatures when IDT_MISR_SIG_EN is defined.
// Revision    : 1.0
// ============================================================================
module idt_vector_player
    import idt_pkg::*;
#(
    parameter int               IN_W     = IDT_IN_W,
    parameter int               OUT_W    = IDT_OUT_W,
    parameter int               DEPTH    = IDT_DEPTH,
    parameter int               ADDR_W   = $clog2(DEPTH),
    parameter int               LAT      = IDT_LAT,
    parameter int               SIG_W    = IDT_SIG_W,
    parameter logic [SIG_W-1:0] SIG_POLY = SIG_W'(IDT_SIG_POLY)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [IN_W-1:0]   cfg_wdata,
    input  logic [ADDR_W:0]   num_vec,
    input  logic              start,
    output logic [IN_W-1:0]   stim,
    input  logic [OUT_W-1:0]  ref_y,
    input  logic [OUT_W-1:0]  dut_y,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   mism_cnt,
    output logic              first_mism_vld,
    output logic [ADDR_W-1:0] first_mism_idx,
    output logic [SIG_W-1:0]  sig_ref,
    output logic [SIG_W-1:0]  sig_dut
);

    localparam int DRAIN_W = (LAT > 1) ? $clog2(LAT) : 1;

    idt_state_e        state_q, state_d;
    logic [ADDR_W:0]   num_q, num_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic [IN_W-1:0]   stim_q, stim_d;
    logic [ADDR_W:0]   mism_cnt_q, mism_cnt_d;
    logic              first_vld_q, first_vld_d;
    logic [ADDR_W-1:0] first_idx_q, first_idx_d;
    logic              pass_q, pass_d;

    logic [IN_W-1:0]   mem_q [DEPTH];
    logic              busy_w;
    logic              start_ok;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W:0]   num_clamp;
    logic              cur_vld;
    logic              smp_vld;
    logic [ADDR_W-1:0] smp_idx;

    assign busy_w    = (state_q == RUN) || (state_q == DRAIN);
    assign start_ok  = start && !busy_w;
    assign cur_vld   = (state_q == RUN);
    assign num_clamp = (num_vec > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : num_vec;

    // Memory contents survive reset so a vector set can be loaded once and replayed.
    always_ff @(posedge clk) begin
        if (cfg_we && !busy_w) begin
            mem_q[cfg_addr] <= cfg_wdata;
        end
    end

    // Carries the index of the vector whose DUT response is due this cycle.
    generate
        if (LAT == 0) begin : g_lat0
            assign smp_vld = cur_vld;
            assign smp_idx = idx_q;
        end else begin : g_lat
            logic [LAT-1:0]             vld_pipe_q, vld_pipe_d;
            logic [LAT-1:0][ADDR_W-1:0] idx_pipe_q, idx_pipe_d;

            always_comb begin
                vld_pipe_d    = vld_pipe_q;
                idx_pipe_d    = idx_pipe_q;
                vld_pipe_d[0] = cur_vld;
                idx_pipe_d[0] = idx_q;
                for (int k = 1; k < LAT; k++) begin
                    vld_pipe_d[k] = vld_pipe_q[k-1];
                    idx_pipe_d[k] = idx_pipe_q[k-1];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_pipe_q <= '0;
                    idx_pipe_q <= '0;
                end else begin
                    vld_pipe_q <= vld_pipe_d;
                    idx_pipe_q <= idx_pipe_d;
                end
            end

            assign smp_vld = vld_pipe_q[LAT-1];
            assign smp_idx = idx_pipe_q[LAT-1];
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        num_d       = num_q;
        idx_d       = idx_q;
        drain_d     = drain_q;
        mism_cnt_d  = mism_cnt_q;
        first_vld_d = first_vld_q;
        first_idx_d = first_idx_q;
        pass_d      = pass_q;
        stim_d      = '0;
        rd_en       = 1'b0;
        rd_addr     = '0;

        if (smp_vld && (ref_y != dut_y)) begin
            if (mism_cnt_q != '1) begin
                mism_cnt_d = mism_cnt_q + (ADDR_W+1)'(1);
            end
            if (!first_vld_q) begin
                first_vld_d = 1'b1;
                first_idx_d = smp_idx;
            end
        end

        case (state_q)
            IDLE, DONE: begin
                if (start_ok) begin
                    mism_cnt_d  = '0;
                    first_vld_d = 1'b0;
                    first_idx_d = '0;
                    pass_d      = 1'b0;
                    num_d       = num_clamp;
                    idx_d       = '0;
                    if (num_clamp == '0) begin
                        state_d = DONE;
                        pass_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                        rd_en   = 1'b1;
                    end
                end
            end
            RUN: begin
                if ({1'b0, idx_q} == num_q - (ADDR_W+1)'(1)) begin
                    if (LAT == 0) begin
                        state_d = DONE;
                        pass_d  = (mism_cnt_d == '0);
                    end else begin
                        state_d = DRAIN;
                        drain_d = DRAIN_W'(LAT - 1);
                    end
                end else begin
                    idx_d   = idx_q + ADDR_W'(1);
                    rd_en   = 1'b1;
                    rd_addr = idx_q + ADDR_W'(1);
                end
            end
            DRAIN: begin
                if (drain_q == '0) begin
                    state_d = DONE;
                    pass_d  = (mism_cnt_d == '0);
                end else begin
                    drain_d = drain_q - DRAIN_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (rd_en) begin
            stim_d = mem_q[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            num_q       <= '0;
            idx_q       <= '0;
            drain_q     <= '0;
            stim_q      <= '0;
            mism_cnt_q  <= '0;
            first_vld_q <= 1'b0;
            first_idx_q <= '0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_q       <= num_d;
            idx_q       <= idx_d;
            drain_q     <= drain_d;
            stim_q      <= stim_d;
            mism_cnt_q  <= mism_cnt_d;
            first_vld_q <= first_vld_d;
            first_idx_q <= first_idx_d;
            pass_q      <= pass_d;
        end
    end

    assign stim           = stim_q;
    assign busy           = busy_w;
    assign done           = (state_q == DONE);
    assign pass           = pass_q;
    assign mism_cnt       = mism_cnt_q;
    assign first_mism_vld = first_vld_q;
    assign first_mism_idx = first_idx_q;

`ifdef IDT_MISR_SIG_EN
    idt_misr #(
        .SIG_W    (SIG_W),
        .OUT_W    (OUT_W),
        .SIG_POLY (SIG_POLY)
    ) u_misr_ref (
        .clk   (clk),
        .rst_n (rst_n),
        .seed  (start_ok),
        .en    (smp_vld),
        .y     (ref_y),
        .sig   (sig_ref)
    );

    idt_misr #(
        .SIG_W    (SIG_W),
        .OUT_W    (OUT_W),
        .SIG_POLY (SIG_POLY)
    ) u_misr_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .seed  (start_ok),
        .en    (smp_vld),
        .y     (dut_y),
        .sig   (sig_dut)
    );
`else
    assign sig_ref = '0;
    assign sig_dut = '0;
`endif

endmodule
`default_nettype wire
